arf_frame_loader: RTL and testbench
===================================

// Module: arf_frame_loader
// PURPOSE
//  Upstream feeder for the ARF accurate datapath. Streams scalar samples into an 8-deep history, latches a coefficient bank,
//  and presents one operand frame (in_k_0 / in_k_1, k=1..8) plus recursive state (in_13_1, in_14_1) per accepted sample.
//  Captures the datapath results (out_27, out_28) as the next frame's recursive state and serialises the recursion.
// PARAMETERS
//  DATA_W      16   sample / state / result width (matches mul_1 / add_3 operand width)
//  COEF_W      16   coefficient width
//  NTAPS       8    history depth = multiplier count of first stage; fixed at 8 for ARF
//  FB_TIMEOUT  64   max cycles to wait for feedback before flagging error (>=2)
// PORTS
//  clk         in   1               single clock, rising edge
//  rst_n       in   1               synchronous, active-low reset
//  flush       in   1               sync clear of history, fill count and recursive state (not coefficients)
//  s_valid     in   1               sample valid
//  s_ready     out  1               sample accept; transfer when s_valid & s_ready
//  s_data      in   DATA_W          sample
//  coef_we     in   1               coefficient write strobe
//  coef_addr   in   3               coefficient index 0..7 (-> in_1_1..in_8_1)
//  coef_data   in   COEF_W          coefficient value
//  frm_valid   out  1               operand frame valid
//  frm_ready   in   1               datapath accepts frame
//  frm_taps    out  NTAPS*DATA_W    slice k-1 = in_k_0; slice 0 = newest sample
//  frm_coef    out  NTAPS*COEF_W    slice k-1 = in_k_1; snapshot taken at issue
//  frm_st13    out  DATA_W          in_13_1 (previous out_27)
//  frm_st14    out  DATA_W          in_14_1 (previous out_28)
//  fb_valid    in   1               datapath results valid (one-cycle pulse)
//  fb_out27    in   DATA_W          out_27
//  fb_out28    in   DATA_W          out_28
//  err_timeout out  1               sticky; cleared by rst_n or flush
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state=ACCEPT; s_ready=0 that cycle then 1; frm_valid=0; history, frm_taps, frm_coef,
//   frm_st13/14, coef bank, fill_cnt, err_timeout all 0.
//  FSM: ACCEPT -> (sample taken & fill_cnt reaches 8) ISSUE -> (frm_ready) WAIT_FB -> (fb_valid) ACCEPT.
//   ACCEPT: s_ready=1. On transfer: history shifts (new at slice 0, slice 7 dropped), fill_cnt saturates at 8.
//    If fill_cnt<8 after shift, stay ACCEPT (no frame). Else next cycle frm_valid=1, coef bank snapshotted to frm_coef.
//   ISSUE: s_ready=0; frm_valid held with all frm_* stable until frm_ready; no timeout here.
//   WAIT_FB: s_ready=0, frm_valid=0; on fb_valid: frm_st13<=fb_out27, frm_st14<=fb_out28, -> ACCEPT.
//    fb_valid outside WAIT_FB ignored. Timer counts cycles in WAIT_FB; at FB_TIMEOUT: err_timeout=1, state regs
//    unchanged, -> ACCEPT. Late fb_valid after timeout ignored.
//  Latency: sample transfer at edge N -> frm_valid high at edge N+1 (registered). Throughput bounded by datapath loop.
//  Coefficient writes accepted in every state, take effect in the next snapshot only; frame in flight unaffected.
//  Simultaneous coef_we and issue snapshot: snapshot sees the OLD value.
//  flush: highest priority after reset; any state -> ACCEPT, frm_valid=0 same edge, history/fill_cnt/st13/st14/timer/
//   err_timeout cleared; coef bank kept. flush & s_valid same cycle: sample dropped, s_ready forced 0 that cycle.
//  No arithmetic; all data paths are pure register transfers, widths unchanged, no truncation.
// STRUCTURE
//  Package arf_pkg: ARF_NTAPS=8, DATA_W/COEF_W defaults, state enum {ACCEPT, ISSUE, WAIT_FB}, tap slice helper.
//  One sub-module: arf_tap_line (NTAPS x DATA_W shift register with enable, clear, fill counter).
//  FSM, coef bank, snapshot, feedback capture and timeout in top level.
// TESTING
//  1 Reset, write coef k=k+1, stream samples 1..8 -> no frame before 8th; frm_valid 1 cycle after 8th;
//    frm_taps slices = 8,7..1; frm_coef = 1..8; st13=st14=0.
//  2 Hold frm_ready=0 for 5 cycles -> frm_* stable, s_ready=0; then frm_ready=1 -> WAIT_FB; fb 0x1234/0x5678
//    -> next frame st13=0x1234, st14=0x5678, taps shifted by one new sample.
//  3 Write coef_addr 3 = 0xAAAA while in WAIT_FB -> current frm_coef unchanged; next frame slice 3 = 0xAAAA.
//  4 Withhold fb_valid 64 cycles -> err_timeout=1 on cycle 64, s_ready=1, st13/14 unchanged; late fb ignored.
//  5 flush during ISSUE with s_valid=1 -> frm_valid=0 next edge, fill_cnt=0, err_timeout=0, coef kept;
//    needs 8 new samples before next frame.
//  6 rst_n low mid-WAIT_FB -> all outputs to reset values; stray fb_valid after reset ignored.

Source files
------------

// File: rtl/arf_pkg.sv
// Shared types and constants for the ARF frame loader: tap geometry, data widths,
// the loader FSM state encoding and a helper that locates a slice in a packed frame.
package arf_pkg;

    localparam int ARF_NTAPS  = 8;
    localparam int ARF_DATA_W = 16;
    localparam int ARF_COEF_W = 16;

    typedef enum logic [1:0] {
        ACCEPT  = 2'd0,
        ISSUE   = 2'd1,
        WAIT_FB = 2'd2
    } arf_state_t;

    // Low bit index of slice k in a packed vector of width-w slices (slice 0 at the LSBs).
    function automatic int tap_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/arf_tap_line.sv
// Sample history for the ARF loader: an NTAPS-deep shift register of DATA_W samples
// with a saturating fill counter. Slice 0 holds the newest sample.
module arf_tap_line
    import arf_pkg::*;
#(
    parameter int NTAPS  = ARF_NTAPS,
    parameter int DATA_W = ARF_DATA_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    shift_en,
    input  logic [DATA_W-1:0]       din,
    output logic [NTAPS*DATA_W-1:0] taps,
    output logic                    will_fill
);

    localparam int CNT_W = $clog2(NTAPS + 1);

    logic [NTAPS*DATA_W-1:0] hist;
    logic [CNT_W-1:0]        fill_cnt;

    // New sample enters at slice 0; the oldest slice falls off the top.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            hist     <= '0;
            fill_cnt <= '0;
        end else if (shift_en) begin
            hist <= {hist[(NTAPS-1)*DATA_W-1:0], din};
            if (fill_cnt != CNT_W'(NTAPS)) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
        end
    end

    // High when the next shift leaves the history completely filled.
    assign will_fill = (fill_cnt >= CNT_W'(NTAPS - 1));
    assign taps      = hist;

endmodule

// File: rtl/arf_frame_loader.sv
// Upstream feeder for the ARF datapath: builds one operand frame per accepted sample once
// the history is full, snapshots the coefficient bank, and serialises the feedback recursion.
module arf_frame_loader
    import arf_pkg::*;
#(
    parameter int DATA_W     = ARF_DATA_W,
    parameter int COEF_W     = ARF_COEF_W,
    parameter int NTAPS      = ARF_NTAPS,
    parameter int FB_TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_W-1:0]       s_data,
    input  logic                    coef_we,
    input  logic [2:0]              coef_addr,
    input  logic [COEF_W-1:0]       coef_data,
    output logic                    frm_valid,
    input  logic                    frm_ready,
    output logic [NTAPS*DATA_W-1:0] frm_taps,
    output logic [NTAPS*COEF_W-1:0] frm_coef,
    output logic [DATA_W-1:0]       frm_st13,
    output logic [DATA_W-1:0]       frm_st14,
    input  logic                    fb_valid,
    input  logic [DATA_W-1:0]       fb_out27,
    input  logic [DATA_W-1:0]       fb_out28,
    output logic                    err_timeout
);

    localparam int TMR_W = $clog2(FB_TIMEOUT + 1);

    arf_state_t        state;
    arf_state_t        state_next;
    logic [COEF_W-1:0] coef_bank [NTAPS];
    logic [TMR_W-1:0]  timer;
    logic              accept_xfer;
    logic              will_fill;
    logic              issue_now;
    logic              timeout_hit;

    assign accept_xfer = s_valid && s_ready;
    assign issue_now   = accept_xfer && will_fill;
    assign timeout_hit = (state == WAIT_FB) && !fb_valid && (timer == TMR_W'(FB_TIMEOUT - 1));

    arf_tap_line #(
        .NTAPS  (NTAPS),
        .DATA_W (DATA_W)
    ) u_tap_line (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (flush),
        .shift_en  (accept_xfer),
        .din       (s_data),
        .taps      (frm_taps),
        .will_fill (will_fill)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ACCEPT;
        end else begin
            state <= state_next;
        end
    end

    // Flush overrides every transition and returns the loader to sample acceptance.
    always_comb begin
        state_next = state;
        case (state)
            ACCEPT:  if (issue_now)                state_next = ISSUE;
            ISSUE:   if (frm_ready)                state_next = WAIT_FB;
            WAIT_FB: if (fb_valid || timeout_hit)  state_next = ACCEPT;
            default:                               state_next = ACCEPT;
        endcase
        if (flush) begin
            state_next = ACCEPT;
        end
    end

    always_comb begin
        s_ready   = 1'b0;
        frm_valid = 1'b0;
        if (rst_n && !flush && (state == ACCEPT)) begin
            s_ready = 1'b1;
        end
        if (state == ISSUE) begin
            frm_valid = 1'b1;
        end
    end

    // Coefficient writes land in the bank only; frames see them at the next snapshot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NTAPS; i++) begin
                coef_bank[i] <= '0;
            end
        end else if (coef_we) begin
            coef_bank[coef_addr] <= coef_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frm_coef <= '0;
        end else if (issue_now) begin
            for (int i = 0; i < NTAPS; i++) begin
                frm_coef[tap_lo(i, COEF_W) +: COEF_W] <= coef_bank[i];
            end
        end
    end

    // Feedback capture and the wait-for-results watchdog; a timeout keeps the old state.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            frm_st13    <= '0;
            frm_st14    <= '0;
            timer       <= '0;
            err_timeout <= 1'b0;
        end else if (state == WAIT_FB) begin
            if (fb_valid) begin
                frm_st13 <= fb_out27;
                frm_st14 <= fb_out28;
                timer    <= '0;
            end else if (timeout_hit) begin
                err_timeout <= 1'b1;
                timer       <= '0;
            end else begin
                timer <= timer + 1'b1;
            end
        end else begin
            timer <= '0;
        end
    end

endmodule

// File: tb/tb_arf_frame_loader.sv
// Self-checking bench for arf_frame_loader: directed scenarios plus random traffic,
// compared every cycle against a behavioural model of the loader.
module tb_arf_frame_loader;

    localparam int DW = 16;
    localparam int CW = 16;
    localparam int NT = 8;
    localparam int TO = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [DW-1:0]   s_data = '0;
    logic            coef_we = 1'b0;
    logic [2:0]      coef_addr = '0;
    logic [CW-1:0]   coef_data = '0;
    logic            frm_valid;
    logic            frm_ready = 1'b0;
    logic [NT*DW-1:0] frm_taps;
    logic [NT*CW-1:0] frm_coef;
    logic [DW-1:0]   frm_st13;
    logic [DW-1:0]   frm_st14;
    logic            fb_valid = 1'b0;
    logic [DW-1:0]   fb_out27 = '0;
    logic [DW-1:0]   fb_out28 = '0;
    logic            err_timeout;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    arf_frame_loader #(
        .DATA_W     (DW),
        .COEF_W     (CW),
        .NTAPS      (NT),
        .FB_TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .coef_we     (coef_we),
        .coef_addr   (coef_addr),
        .coef_data   (coef_data),
        .frm_valid   (frm_valid),
        .frm_ready   (frm_ready),
        .frm_taps    (frm_taps),
        .frm_coef    (frm_coef),
        .frm_st13    (frm_st13),
        .frm_st14    (frm_st14),
        .fb_valid    (fb_valid),
        .fb_out27    (fb_out27),
        .fb_out28    (fb_out28),
        .err_timeout (err_timeout)
    );

    // Behavioural model: history list, coefficient bank, frame snapshot and two phase flags.
    logic [DW-1:0] m_hist [NT];
    logic [CW-1:0] m_coef [NT];
    logic [CW-1:0] m_snap [NT];
    logic [DW-1:0] m_st13 = '0;
    logic [DW-1:0] m_st14 = '0;
    int            m_fill = 0;
    bit            m_present = 1'b0;
    bit            m_await = 1'b0;
    int            m_waited = 0;
    bit            m_err = 1'b0;

    function automatic logic [127:0] pack8(input logic [15:0] a [NT]);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < NT; i++) r[i*16 +: 16] = a[i];
        return r;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NT; i++) begin
                m_hist[i] = '0;
                m_coef[i] = '0;
                m_snap[i] = '0;
            end
            m_st13 = '0; m_st14 = '0; m_fill = 0;
            m_present = 0; m_await = 0; m_waited = 0; m_err = 0;
        end else begin
            if (flush) begin
                for (int i = 0; i < NT; i++) m_hist[i] = '0;
                m_st13 = '0; m_st14 = '0; m_fill = 0;
                m_present = 0; m_await = 0; m_waited = 0; m_err = 0;
            end else if (!m_present && !m_await) begin
                if (s_valid) begin
                    for (int i = NT - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
                    m_hist[0] = s_data;
                    if (m_fill < NT) m_fill++;
                    if (m_fill == NT) begin
                        m_present = 1;
                        for (int i = 0; i < NT; i++) m_snap[i] = m_coef[i];
                    end
                end
            end else if (m_present) begin
                if (frm_ready) begin
                    m_present = 0;
                    m_await   = 1;
                    m_waited  = 0;
                end
            end else begin
                if (fb_valid) begin
                    m_st13  = fb_out27;
                    m_st14  = fb_out28;
                    m_await = 0;
                end else begin
                    m_waited++;
                    if (m_waited == TO) begin
                        m_err   = 1;
                        m_await = 0;
                    end
                end
            end
            if (coef_we) m_coef[coef_addr] = coef_data;
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("s_ready",     128'(s_ready),     128'(rst_n && !flush && !m_present && !m_await));
            checkOutput("frm_valid",   128'(frm_valid),   128'(m_present));
            checkOutput("frm_taps",    128'(frm_taps),    pack8(m_hist));
            checkOutput("frm_coef",    128'(frm_coef),    pack8(m_snap));
            checkOutput("frm_st13",    128'(frm_st13),    128'(m_st13));
            checkOutput("frm_st14",    128'(frm_st14),    128'(m_st14));
            checkOutput("err_timeout", 128'(err_timeout), 128'(m_err));
        end
    end

    task automatic applyStimulus(input logic sv, input logic [15:0] sd, input logic fr,
                                 input logic fbv, input logic [15:0] f27, input logic [15:0] f28,
                                 input logic cwe, input logic [2:0] ca, input logic [15:0] cd,
                                 input logic fl, input logic rn);
        s_valid = sv; s_data = sd; frm_ready = fr;
        fb_valid = fbv; fb_out27 = f27; fb_out28 = f28;
        coef_we = cwe; coef_addr = ca; coef_data = cd;
        flush = fl; rst_n = rn;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        // Reset, coefficient load and first frame fill
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_en = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rst_s_ready", 128'(s_ready), 128'd0);
        checkOutput("rst_frm_valid", 128'(frm_valid), 128'd0);
        checkOutput("rst_err", 128'(err_timeout), 128'd0);
        for (int k = 0; k < NT; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 1, 3'(k), 16'(k + 1), 0, 1);
        end
        checkOutput("post_rst_s_ready", 128'(s_ready), 128'd1);
        for (int i = 1; i <= NT; i++) begin
            applyStimulus(1, 16'(i), 0, 0, 0, 0, 0, 0, 0, 0, 1);
            checkOutput("fill_frm_valid", 128'(frm_valid), (i == NT) ? 128'd1 : 128'd0);
        end
        checkOutput("first_taps", 128'(frm_taps), 128'h0001_0002_0003_0004_0005_0006_0007_0008);
        checkOutput("first_coef", 128'(frm_coef), 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        checkOutput("first_st13", 128'(frm_st13), 128'd0);

        // Backpressure hold, then handshake into the feedback wait
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1, 16'h00ff, 0, 0, 0, 0, 0, 0, 0, 0, 1);
            checkOutput("hold_taps", 128'(frm_taps), 128'h0001_0002_0003_0004_0005_0006_0007_0008);
            checkOutput("hold_s_ready", 128'(s_ready), 128'd0);
        end
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("wait_frm_valid", 128'(frm_valid), 128'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 3'd3, 16'hAAAA, 0, 1);
        checkOutput("inflight_coef", 128'(frm_coef), 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        applyStimulus(0, 0, 0, 1, 16'h1234, 16'h5678, 0, 0, 0, 0, 1);
        checkOutput("fb_st13", 128'(frm_st13), 128'h1234);
        checkOutput("fb_st14", 128'(frm_st14), 128'h5678);
        applyStimulus(1, 16'd9, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("second_valid", 128'(frm_valid), 128'd1);
        checkOutput("second_taps", 128'(frm_taps), 128'h0002_0003_0004_0005_0006_0007_0008_0009);
        checkOutput("second_coef", 128'(frm_coef), 128'h0008_0007_0006_0005_AAAA_0003_0002_0001);

        // Feedback watchdog
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int c = 1; c <= TO; c++) begin
            idle();
            if (c == TO - 1) checkOutput("pre_timeout_err", 128'(err_timeout), 128'd0);
            if (c == TO) begin
                checkOutput("timeout_err", 128'(err_timeout), 128'd1);
                checkOutput("timeout_s_ready", 128'(s_ready), 128'd1);
                checkOutput("timeout_st13", 128'(frm_st13), 128'h1234);
            end
        end
        applyStimulus(0, 0, 0, 1, 16'hDEAD, 16'hBEEF, 0, 0, 0, 0, 1);
        checkOutput("late_fb_st13", 128'(frm_st13), 128'h1234);
        checkOutput("late_fb_st14", 128'(frm_st14), 128'h5678);

        // Flush while a frame is presented
        applyStimulus(1, 16'h0010, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("pre_flush_valid", 128'(frm_valid), 128'd1);
        applyStimulus(1, 16'h0011, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        checkOutput("flush_s_ready", 128'(s_ready), 128'd0);
        checkOutput("flush_frm_valid", 128'(frm_valid), 128'd0);
        checkOutput("flush_err", 128'(err_timeout), 128'd0);
        checkOutput("flush_taps", 128'(frm_taps), 128'd0);
        for (int i = 1; i <= NT; i++) begin
            applyStimulus(1, 16'(16'h20 + i), 0, 0, 0, 0, 0, 0, 0, 0, 1);
            checkOutput("refill_frm_valid", 128'(frm_valid), (i == NT) ? 128'd1 : 128'd0);
        end
        checkOutput("refill_coef", 128'(frm_coef), 128'h0008_0007_0006_0005_AAAA_0003_0002_0001);

        // Reset in the middle of a feedback wait
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("midrst_frm_valid", 128'(frm_valid), 128'd0);
        checkOutput("midrst_coef", 128'(frm_coef), 128'd0);
        checkOutput("midrst_taps", 128'(frm_taps), 128'd0);
        applyStimulus(0, 0, 0, 1, 16'h4321, 16'h8765, 0, 0, 0, 0, 1);
        checkOutput("stray_fb_st13", 128'(frm_st13), 128'd0);
        checkOutput("stray_fb_s_ready", 128'(s_ready), 128'd1);

        // Random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            applyStimulus(1'($urandom_range(0, 9) < 6), 16'($urandom), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 19) < 3), 16'($urandom), 16'($urandom),
                          1'($urandom_range(0, 4) == 0), 3'($urandom_range(0, 7)), 16'($urandom),
                          1'($urandom_range(0, 99) < 2), 1'($urandom_range(0, 299) != 0));
        end
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
